// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath whose memory
// may insert wait states. The unit decodes op/func into per-state strobes,
// traps illegal opcodes and memory timeouts into a sticky error code, and
// counts retired instructions.
// Strobes are a combinational function of the current state and inputs, so
// that they can follow mem_ready, Zero and Overflow within the same cycle
// and drop at once when rst rises.
module multicycle_ctrl #(
    parameter int ALUCTR_W    = 3,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                Zero,
    input  logic                Overflow,
    input  logic                mem_ready,
    output logic                IRWr,
    output logic                PCWr,
    output logic [1:0]          PC_Sel,
    output logic                RegDst,
    output logic                RegWr,
    output logic                ALUSrc,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic                MemRd,
    output logic                MemWr,
    output logic                MemtoReg,
    output logic                Extop,
    output logic [2:0]          state,
    output logic [1:0]          err,
    output logic [CNT_W-1:0]    retired
);

    // State encodings (also exported on the debug port).
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd7;

    // Opcodes.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes.
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes, zero-extended to the port width.
    localparam logic [ALUCTR_W-1:0] ALU_ADD = ALUCTR_W'(3'b000);
    localparam logic [ALUCTR_W-1:0] ALU_SUB = ALUCTR_W'(3'b001);
    localparam logic [ALUCTR_W-1:0] ALU_AND = ALUCTR_W'(3'b010);
    localparam logic [ALUCTR_W-1:0] ALU_OR  = ALUCTR_W'(3'b011);
    localparam logic [ALUCTR_W-1:0] ALU_SLT = ALUCTR_W'(3'b100);

    // Error codes.
    localparam logic [1:0] E_NONE    = 2'b00;
    localparam logic [1:0] E_ILLEGAL = 2'b01;
    localparam logic [1:0] E_TIMEOUT = 2'b10;

    // Wait counter must be able to hold MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    // True when op/func names an instruction this unit implements.
    function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
        logic ok;
        case (o)
            OP_RTYPE: begin
                case (f)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default:                               ok = 1'b0;
                endcase
            end
            OP_ADDIU, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU code for an R-type function field.
    function automatic logic [ALUCTR_W-1:0] r_aluctr(input logic [5:0] f);
        logic [ALUCTR_W-1:0] a;
        case (f)
            FN_ADD:  a = ALU_ADD;
            FN_SUB:  a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    logic [2:0]          state_q,   state_d;
    logic [1:0]          err_q,     err_d;
    logic [WAIT_W-1:0]   wait_q,    wait_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic                is_r_s;
    logic                is_lw_s;
    logic                is_sw_s;
    logic                legal_s;
    logic                ovf_trap_s;
    logic                mem_tmo_s;
    logic                retire_s;
    logic [ALUCTR_W-1:0] alu_op_s;
    logic                alu_src_s;
    logic                ext_s;

    assign is_r_s     = (op == OP_RTYPE);
    assign is_lw_s    = (op == OP_LW);
    assign is_sw_s    = (op == OP_SW);
    assign legal_s    = is_legal(op, func);
    // Signed overflow on add/sub suppresses the write but does not trap.
    assign ovf_trap_s = is_r_s && ((func == FN_ADD) || (func == FN_SUB)) && Overflow;
    // This is the last allowed not-ready cycle of a memory access.
    assign mem_tmo_s  = (wait_q == WAIT_LAST);

    // ALU operation implied by the current instruction.
    always_comb begin
        alu_op_s  = ALU_ADD;
        alu_src_s = 1'b0;
        ext_s     = 1'b0;
        case (op)
            OP_RTYPE: begin
                alu_op_s = r_aluctr(func);
            end
            OP_ADDIU, OP_LW, OP_SW: begin
                alu_op_s  = ALU_ADD;
                alu_src_s = 1'b1;
                ext_s     = 1'b1;
            end
            OP_ORI: begin
                alu_op_s  = ALU_OR;
                alu_src_s = 1'b1;
                ext_s     = 1'b0;
            end
            OP_BEQ: begin
                alu_op_s = ALU_SUB;
            end
            default: begin
                alu_op_s  = ALU_ADD;
                alu_src_s = 1'b0;
                ext_s     = 1'b0;
            end
        endcase
    end

    // State, sticky error, wait counter and retire counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            err_q     <= E_NONE;
            wait_q    <= {WAIT_W{1'b0}};
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // Next-state, error capture, wait counting and retirement.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        wait_d   = wait_q;
        retire_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (mem_tmo_s) begin
                    state_d = S_ERR;
                    err_d   = E_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (legal_s) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ERR;
                    err_d   = E_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ, OP_J: begin
                        state_d  = S_FETCH;
                        retire_s = 1'b1;
                    end
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_lw_s) begin
                        state_d = S_WB;
                    end else begin
                        state_d  = S_FETCH;
                        retire_s = 1'b1;
                    end
                end else if (mem_tmo_s) begin
                    state_d = S_ERR;
                    err_d   = E_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                // Unused encodings are treated as a corrupted sequencer.
                state_d = S_ERR;
                err_d   = E_ILLEGAL;
            end
        endcase

        // Every state change starts a fresh wait window.
        if (state_d != state_q) begin
            wait_d = {WAIT_W{1'b0}};
        end else begin
            wait_d = wait_d;
        end

        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // Per-state datapath strobes; forced low while reset is asserted.
    always_comb begin
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        PC_Sel   = 2'b00;
        RegDst   = 1'b0;
        RegWr    = 1'b0;
        ALUSrc   = 1'b0;
        ALUctr   = ALU_ADD;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        MemtoReg = 1'b0;
        Extop    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    MemRd = 1'b1;
                    if (mem_ready) begin
                        IRWr   = 1'b1;
                        PCWr   = 1'b1;
                        PC_Sel = 2'b00;
                    end else begin
                        IRWr = 1'b0;
                        PCWr = 1'b0;
                    end
                end
                S_EXEC: begin
                    ALUctr = alu_op_s;
                    ALUSrc = alu_src_s;
                    Extop  = ext_s;
                    case (op)
                        OP_BEQ: begin
                            PCWr   = Zero;
                            PC_Sel = 2'b01;
                        end
                        OP_J: begin
                            PCWr   = 1'b1;
                            PC_Sel = 2'b10;
                        end
                        default: begin
                            PCWr   = 1'b0;
                            PC_Sel = 2'b00;
                        end
                    endcase
                end
                S_MEM: begin
                    // Address computation stays on the ALU for the whole access.
                    ALUctr = ALU_ADD;
                    ALUSrc = 1'b1;
                    Extop  = 1'b1;
                    MemRd  = is_lw_s;
                    MemWr  = is_sw_s;
                end
                S_WB: begin
                    RegWr    = !ovf_trap_s;
                    RegDst   = is_r_s;
                    MemtoReg = is_lw_s;
                    if (!is_lw_s) begin
                        // ALU result (and Overflow) must stay valid through write-back.
                        ALUctr = alu_op_s;
                        ALUSrc = alu_src_s;
                        Extop  = ext_s;
                    end else begin
                        ALUctr = ALU_ADD;
                    end
                end
                S_DECODE, S_ERR: begin
                    IRWr = 1'b0;
                end
                default: begin
                    IRWr = 1'b0;
                end
            endcase
        end else begin
            IRWr = 1'b0;
        end
    end

    assign state   = state_q;
    assign err     = err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        Zero;
    logic        Overflow;
    logic        mem_ready;
    logic        IRWr;
    logic        PCWr;
    logic [1:0]  PC_Sel;
    logic        RegDst;
    logic        RegWr;
    logic        ALUSrc;
    logic [2:0]  ALUctr;
    logic        MemRd;
    logic        MemWr;
    logic        MemtoReg;
    logic        Extop;
    logic [2:0]  state;
    logic [1:0]  err;
    logic [31:0] retired;

    logic [13:0] strb;
    assign strb = {IRWr, PCWr, PC_Sel, RegDst, RegWr, ALUSrc, ALUctr, MemRd, MemWr, MemtoReg, Extop};

    int n_chk  = 0;
    int n_pass = 0;
    int exp_ret = 0;

    multicycle_ctrl #(.ALUCTR_W(3), .CNT_W(32), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .Zero(Zero), .Overflow(Overflow),
        .mem_ready(mem_ready), .IRWr(IRWr), .PCWr(PCWr), .PC_Sel(PC_Sel), .RegDst(RegDst),
        .RegWr(RegWr), .ALUSrc(ALUSrc), .ALUctr(ALUctr), .MemRd(MemRd), .MemWr(MemWr),
        .MemtoReg(MemtoReg), .Extop(Extop), .state(state), .err(err), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ret = 0;
    endtask

    // Run one instruction from FETCH with mem_ready held high and check its trace.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input logic v, input int exp_len, input int exp_rw,
                             input logic [2:0] exp_alu, input logic exp_pcwr,
                             input logic [1:0] exp_sel, input int exp_m2r);
        int n, rw, irw, m2r;
        logic [2:0] alu_e;
        logic       pcwr_e;
        logic [1:0] sel_e;
        op = o; func = f; Zero = z; Overflow = v; mem_ready = 1'b1;
        n = 0; rw = 0; irw = 0; m2r = 0;
        alu_e = 3'b111; pcwr_e = 1'b0; sel_e = 2'b11;
        do begin
            #1;
            rw  += int'(RegWr);
            irw += int'(IRWr);
            m2r += int'(MemtoReg);
            if (state == 3'd2) begin
                alu_e  = ALUctr;
                pcwr_e = PCWr;
                sel_e  = PC_Sel;
            end
            @(posedge clk);
            #1;
            n++;
        end while (state != 3'd0 && n < 12);
        exp_ret++;
        chk({tag, "_len"}, n, exp_len);
        chk({tag, "_regwr"}, rw, exp_rw);
        chk({tag, "_irwr"}, irw, 1);
        chk({tag, "_alu"}, alu_e, exp_alu);
        chk({tag, "_pcwr"}, pcwr_e, exp_pcwr);
        if (exp_pcwr) chk({tag, "_pcsel"}, sel_e, exp_sel);
        chk({tag, "_m2r"}, m2r, exp_m2r);
        chk({tag, "_retired"}, retired, exp_ret);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int rd_n;
        rst = 1'b1; op = 6'd0; func = 6'd0; Zero = 1'b0; Overflow = 1'b0; mem_ready = 1'b1;
        repeat (2) tick();
        chk("rst_state", state, 3'd0);
        chk("rst_err", err, 2'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_strobes", strb, 14'd0);
        rst = 1'b0;
        exp_ret = 0;

        //        tag      op         func       Z     V     len rw alu     pcwr  sel    m2r
        run_instr("add",   6'b000000, 6'b100000, 1'b0, 1'b0, 4, 1, 3'b000, 1'b0, 2'b00, 0);
        run_instr("sub",   6'b000000, 6'b100010, 1'b0, 1'b0, 4, 1, 3'b001, 1'b0, 2'b00, 0);
        chk("addsub_retired", retired, 32'd2);
        run_instr("and",   6'b000000, 6'b100100, 1'b0, 1'b0, 4, 1, 3'b010, 1'b0, 2'b00, 0);
        run_instr("or",    6'b000000, 6'b100101, 1'b0, 1'b0, 4, 1, 3'b011, 1'b0, 2'b00, 0);
        run_instr("slt",   6'b000000, 6'b101010, 1'b0, 1'b0, 4, 1, 3'b100, 1'b0, 2'b00, 0);
        run_instr("addiu", 6'b001001, 6'b000000, 1'b0, 1'b0, 4, 1, 3'b000, 1'b0, 2'b00, 0);
        run_instr("ori",   6'b001101, 6'b000000, 1'b0, 1'b0, 4, 1, 3'b011, 1'b0, 2'b00, 0);
        run_instr("sw",    6'b101011, 6'b000000, 1'b0, 1'b0, 4, 0, 3'b000, 1'b0, 2'b00, 0);
        run_instr("lw",    6'b100011, 6'b000000, 1'b0, 1'b0, 5, 1, 3'b000, 1'b0, 2'b00, 1);
        run_instr("beq_t", 6'b000100, 6'b000000, 1'b1, 1'b0, 3, 0, 3'b001, 1'b1, 2'b01, 0);
        run_instr("beq_n", 6'b000100, 6'b000000, 1'b0, 1'b0, 3, 0, 3'b001, 1'b0, 2'b01, 0);
        run_instr("j",     6'b000010, 6'b000000, 1'b0, 1'b0, 3, 0, 3'b000, 1'b1, 2'b10, 0);
        run_instr("addovf",6'b000000, 6'b100000, 1'b0, 1'b1, 4, 0, 3'b000, 1'b0, 2'b00, 0);

        // lw with three wait states in MEM.
        do_reset();
        op = 6'b100011; func = 6'd0; Overflow = 1'b0; mem_ready = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;
        rd_n = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            rd_n += int'(MemRd);
            if (state != 3'd3 || ALUctr != 3'b000) bad++;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        rd_n += int'(MemRd);
        chk("lwwait_mem_state", state, 3'd3);
        tick();
        chk("lwwait_wb_state", state, 3'd4);
        chk("lwwait_wb_ctl", {MemtoReg, RegWr, RegDst}, 3'b110);
        tick();
        chk("lwwait_memrd_cycles", rd_n, 4);
        chk("lwwait_hold_bad", bad, 0);
        chk("lwwait_end_state", state, 3'd0);
        chk("lwwait_retired", retired, 32'd1);

        // Illegal opcode traps and the error state absorbs.
        do_reset();
        op = 6'b111111; mem_ready = 1'b1; Zero = 1'b1;
        tick();
        chk("ill_decode", state, 3'd1);
        tick();
        chk("ill_state", state, 3'd7);
        chk("ill_err", err, 2'b01);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (strb != 14'd0 || state != 3'd7 || err != 2'b01) bad++;
            tick();
        end
        chk("ill_absorb_bad", bad, 0);
        chk("ill_retired", retired, 32'd0);

        // Fetch timeout after 15 not-ready cycles.
        do_reset();
        op = 6'b000000; func = 6'b100000; Zero = 1'b0; mem_ready = 1'b0;
        repeat (14) tick();
        #1;
        chk("tmo_pre_state", state, 3'd0);
        chk("tmo_pre_err", err, 2'b00);
        tick();
        chk("tmo_state", state, 3'd7);
        chk("tmo_err", err, 2'b10);
        chk("tmo_strobes", strb, 14'd0);

        // Ready arriving in the 15th cycle wins over the timeout.
        do_reset();
        mem_ready = 1'b0;
        repeat (14) tick();
        mem_ready = 1'b1;
        #1;
        chk("tmo_ok_irwr", IRWr, 1'b1);
        tick();
        chk("tmo_ok_state", state, 3'd1);
        chk("tmo_ok_err", err, 2'b00);

        // Reset asserted during the MEM state of sw drops MemWr at once.
        do_reset();
        op = 6'b101011; mem_ready = 1'b1;
        run_instr("sw_pre", 6'b101011, 6'b000000, 1'b0, 1'b0, 4, 0, 3'b000, 1'b0, 2'b00, 0);
        repeat (3) tick();
        mem_ready = 1'b0;
        #1;
        chk("rstmem_state", state, 3'd3);
        chk("rstmem_memwr_before", MemWr, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmem_memwr_after", MemWr, 1'b0);
        chk("rstmem_state_after", state, 3'd0);
        chk("rstmem_retired", retired, 32'd0);
        tick();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
